// File: rtl/binpack_pkg.sv
// Shared types and sizing helpers for the binary pixel packer.
//   state_t      : packer FSM state {IDLE, ACTIVE}
//   calc_wpl     : words per line, ceil(h / w)
//   calc_addr_w  : frame-buffer word address width
//   calc_cnt_w   : width able to hold a full-frame pixel count
package binpack_pkg;
  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic int calc_wpl(input int h, input int w);
    return (h + w - 1) / w;
  endfunction

  function automatic int calc_addr_w(input int h, input int w, input int v);
    return $clog2(calc_wpl(h, w) * v);
  endfunction

  function automatic int calc_cnt_w(input int h, input int v);
    return $clog2(h * v + 1);
  endfunction
endpackage

// File: rtl/bit_accum.sv
// Word accumulator: gathers pixels LSB-first into a WORD_W-bit word.
//   clk, rst : clock, async active-high reset
//   pix      : incoming pixel bit
//   en       : accept pix this cycle
//   clr      : drop partial word; an accepted pix becomes bit 0
//   flush    : the accepted pix ends the word early (unfilled bits stay 0)
//   word     : word including this cycle's pix (combinational, top registers it)
//   full     : this cycle's pix lands in the top bit
module bit_accum #(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix,
  input  logic              en,
  input  logic              clr,
  input  logic              flush,
  output logic [WORD_W-1:0] word,
  output logic              full
);
  localparam int IDX_W = $clog2(WORD_W);

  logic [WORD_W-1:0] acc;
  logic [IDX_W-1:0]  idx;
  logic [WORD_W-1:0] base_acc;
  logic [IDX_W-1:0]  base_idx;

  // clr acts in the same cycle so a restart pixel sees an empty word
  always_comb begin
    base_acc = clr ? '0 : acc;
    base_idx = clr ? '0 : idx;
    word     = base_acc | (WORD_W'(en & pix) << base_idx);
    full     = (base_idx == IDX_W'(WORD_W - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      idx <= '0;
    end else if (en) begin
      if (full || flush) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= word;
        idx <= base_idx + IDX_W'(1);
      end
    end else if (clr) begin
      acc <= '0;
      idx <= '0;
    end
  end
endmodule

// File: rtl/binary_pixel_packer.sv
// Packs a 1-bit pixel stream LSB-first into WORD_W-bit frame-buffer words.
// Every line starts on a word boundary; a line ends on eol_in or after
// H_PIXELS pixels (excess pixels up to the next eol_in are dropped).
//   clk_in, rst_in   : clock, async active-high reset
//   pixel_in         : thresholded pixel
//   valid_in         : pixel_in/sof_in/eol_in qualified
//   sof_in, eol_in   : first pixel of frame / last pixel of line
//   wr_en_out        : BRAM write strobe
//   wr_addr_out      : word address (line_base + word_idx)
//   wr_data_out      : packed word, pixel k in bit k
//   frame_done_out   : pulses with the last write of a frame
//   frame_err_out    : pulses when sof_in arrives mid-frame
//   popcount_out     : set-pixel count of last frame
// Build option: PACKER_POPCOUNT_EN enables the set-pixel counter; otherwise
// popcount_out is tied to 0.
module binary_pixel_packer import binpack_pkg::*; #(
  parameter  int WORD_W   = 16,
  parameter  int H_PIXELS = 320,
  parameter  int V_LINES  = 240,
  localparam int WPL      = calc_wpl(H_PIXELS, WORD_W),
  localparam int ADDR_W   = calc_addr_w(H_PIXELS, WORD_W, V_LINES),
  localparam int CNT_W    = calc_cnt_w(H_PIXELS, V_LINES)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              pixel_in,
  input  logic              valid_in,
  input  logic              sof_in,
  input  logic              eol_in,
  output logic              wr_en_out,
  output logic [ADDR_W-1:0] wr_addr_out,
  output logic [WORD_W-1:0] wr_data_out,
  output logic              frame_done_out,
  output logic              frame_err_out,
  output logic [CNT_W-1:0]  popcount_out
);
  localparam int PC_W = $clog2(H_PIXELS + 1);
  localparam int LN_W = $clog2(V_LINES + 1);
  localparam int WI_W = $clog2(WPL + 1);
  localparam logic [PC_W-1:0]   PIX_LAST  = PC_W'(H_PIXELS - 1);
  localparam logic [LN_W-1:0]   LINE_LAST = LN_W'(V_LINES - 1);
  localparam logic [ADDR_W-1:0] WPL_A     = ADDR_W'(WPL);

  state_t            state_q, state_d;
  logic              drop_q, drop_d;
  logic [PC_W-1:0]   pix_q, pix_e;
  logic [LN_W-1:0]   line_q, line_e;
  logic [WI_W-1:0]   word_q, word_e;
  logic [ADDR_W-1:0] base_q, base_e;
  logic              new_frame, accept, eol_end, do_wr, done, err;
  logic [WORD_W-1:0] acc_word;
  logic              acc_full;

  // sof_in restarts position tracking in the same cycle as its pixel
  assign new_frame = valid_in & sof_in;
  assign pix_e  = new_frame ? '0 : pix_q;
  assign line_e = new_frame ? '0 : line_q;
  assign word_e = new_frame ? '0 : word_q;
  assign base_e = new_frame ? '0 : base_q;

  bit_accum #(.WORD_W(WORD_W)) u_accum (
    .clk   (clk_in),
    .rst   (rst_in),
    .pix   (pixel_in),
    .en    (accept),
    .clr   (new_frame),
    .flush (eol_end),
    .word  (acc_word),
    .full  (acc_full)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    accept  = 1'b0;
    eol_end = 1'b0;
    do_wr   = 1'b0;
    done    = 1'b0;
    err     = new_frame & (state_q == ACTIVE);
    if (valid_in) begin
      if (sof_in || (state_q == ACTIVE && !drop_q)) begin
        accept  = 1'b1;
        state_d = ACTIVE;
        eol_end = eol_in | (pix_e == PIX_LAST);
        do_wr   = eol_end | acc_full;
        // forced line end: swallow pixels until the stream's own eol_in
        drop_d  = eol_end & ~eol_in;
        if (eol_end && line_e == LINE_LAST) begin
          done    = 1'b1;
          state_d = IDLE;
          drop_d  = 1'b0;
        end
      end else if (state_q == ACTIVE && eol_in) begin
        drop_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      drop_q         <= 1'b0;
      pix_q          <= '0;
      line_q         <= '0;
      word_q         <= '0;
      base_q         <= '0;
      wr_en_out      <= 1'b0;
      wr_addr_out    <= '0;
      wr_data_out    <= '0;
      frame_done_out <= 1'b0;
      frame_err_out  <= 1'b0;
    end else begin
      drop_q         <= drop_d;
      wr_en_out      <= do_wr;
      frame_done_out <= done;
      frame_err_out  <= err;
      if (do_wr) begin
        wr_addr_out <= base_e + ADDR_W'(word_e);
        wr_data_out <= acc_word;
      end
      if (accept) begin
        if (eol_end) begin
          pix_q  <= '0;
          word_q <= '0;
          line_q <= line_e + LN_W'(1);
          base_q <= base_e + WPL_A;
        end else begin
          pix_q  <= pix_e + PC_W'(1);
          line_q <= line_e;
          base_q <= base_e;
          word_q <= acc_full ? word_e + WI_W'(1) : word_e;
        end
      end
    end
  end

`ifdef PACKER_POPCOUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_e, cnt_n;
  assign cnt_e = new_frame ? '0 : cnt_q;
  assign cnt_n = cnt_e + CNT_W'(pixel_in);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q        <= '0;
      popcount_out <= '0;
    end else if (accept) begin
      cnt_q <= cnt_n;
      if (done) popcount_out <= cnt_n;
    end
  end
`else
  assign popcount_out = '0;
`endif
endmodule

// File: tb/tb_binary_pixel_packer.sv
module tb_binary_pixel_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // full-size instance
  logic        b_pix = 0, b_vld = 0, b_sof = 0, b_eol = 0;
  logic        b_we, b_fd, b_fe;
  logic [12:0] b_wa;
  logic [15:0] b_wd;
  logic [16:0] b_pc;
  // small instance: 20 pixels x 4 lines, 2 words per line
  logic        s_pix = 0, s_vld = 0, s_sof = 0, s_eol = 0;
  logic        s_we, s_fd, s_fe;
  logic [2:0]  s_wa;
  logic [15:0] s_wd;
  logic [6:0]  s_pc;

  binary_pixel_packer #(.WORD_W(16), .H_PIXELS(320), .V_LINES(240)) u_big (
    .clk_in(clk), .rst_in(rst), .pixel_in(b_pix), .valid_in(b_vld),
    .sof_in(b_sof), .eol_in(b_eol), .wr_en_out(b_we), .wr_addr_out(b_wa),
    .wr_data_out(b_wd), .frame_done_out(b_fd), .frame_err_out(b_fe),
    .popcount_out(b_pc));

  binary_pixel_packer #(.WORD_W(16), .H_PIXELS(20), .V_LINES(4)) u_small (
    .clk_in(clk), .rst_in(rst), .pixel_in(s_pix), .valid_in(s_vld),
    .sof_in(s_sof), .eol_in(s_eol), .wr_en_out(s_we), .wr_addr_out(s_wa),
    .wr_data_out(s_wd), .frame_done_out(s_fd), .frame_err_out(s_fe),
    .popcount_out(s_pc));

  int n_cmp = 0, n_bad = 0;
  int ba[$], bd[$], sa[$], sd[$];
  bit bf[$], sf[$];
  int b_done_n = 0, b_err_n = 0, s_done_n = 0, s_err_n = 0;

  always @(negedge clk) begin
    if (b_we) begin ba.push_back(int'(b_wa)); bd.push_back(int'(b_wd)); bf.push_back(b_fd); end
    if (s_we) begin sa.push_back(int'(s_wa)); sd.push_back(int'(s_wd)); sf.push_back(s_fd); end
    if (b_fd) b_done_n++;
    if (b_fe) b_err_n++;
    if (s_fd) s_done_n++;
    if (s_fe) s_err_n++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int pc_exp(input int v);
`ifdef PACKER_POPCOUNT_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic drv(input bit sm, input bit p, input bit s, input bit e);
    @(posedge clk); #1;
    if (sm) begin s_vld = 1; s_pix = p; s_sof = s; s_eol = e; end
    else    begin b_vld = 1; b_pix = p; b_sof = s; b_eol = e; end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      b_vld = 0; b_sof = 0; b_eol = 0;
      s_vld = 0; s_sof = 0; s_eol = 0;
    end
  endtask

  task automatic exp_s(input string tag, input int a, input int d, input bit f);
    chk({tag, "_present"}, (sa.size() > 0) ? 1 : 0, 1);
    if (sa.size() > 0) begin
      chk({tag, "_addr"}, sa.pop_front(), a);
      chk({tag, "_data"}, sd.pop_front(), d);
      chk({tag, "_done"}, int'(sf.pop_front()), int'(f));
    end
  endtask

  initial begin
    int bad_a, bad_d, bad_f;
    repeat (2) @(negedge clk);
    chk("rst_we", int'(b_we), 0);
    chk("rst_addr", int'(b_wa), 0);
    chk("rst_data", int'(b_wd), 0);
    chk("rst_flags", int'({b_fd, b_fe, s_fd, s_fe, s_we}), 0);
    chk("rst_popcount", int'(b_pc), 0);
    @(posedge clk); #1 rst = 0;

    // full frame, alternating 1,0, eol each line
    for (int l = 0; l < 240; l++)
      for (int k = 0; k < 320; k++)
        drv(0, (k % 2) == 0, (l == 0) && (k == 0), k == 319);
    gap(4);
    chk("big_writes", ba.size(), 4800);
    bad_a = 0; bad_d = 0; bad_f = 0;
    foreach (ba[i]) begin
      if (ba[i] != i) bad_a++;
      if (bd[i] != 16'h5555) bad_d++;
      if (bf[i] != (i == 4799)) bad_f++;
    end
    chk("big_bad_addr", bad_a, 0);
    chk("big_bad_data", bad_d, 0);
    chk("big_done_pos", bad_f, 0);
    chk("big_done_cnt", b_done_n, 1);
    chk("big_err_cnt", b_err_n, 0);
    chk("big_popcount", int'(b_pc), pc_exp(38400));

    // frame A: full line, short line, overlong line, short last line
    for (int k = 0; k < 20; k++) drv(1, 1, k == 0, k == 19);
    for (int k = 0; k < 5; k++)  drv(1, 1, 0, k == 4);
    for (int k = 0; k < 25; k++) drv(1, 1, 0, 0);
    drv(1, 1, 0, 1);
    drv(1, 1, 0, 0); drv(1, 0, 0, 0); drv(1, 1, 0, 1);
    gap(3);
    exp_s("a_l0w0", 0, 16'hFFFF, 0);
    exp_s("a_l0w1", 1, 16'h000F, 0);
    exp_s("a_l1w0", 2, 16'h001F, 0);
    exp_s("a_l2w0", 4, 16'hFFFF, 0);
    exp_s("a_l2w1", 5, 16'h000F, 0);
    exp_s("a_l3w0", 6, 16'h0005, 1);
    chk("a_extra", sa.size(), 0);
    chk("a_done_cnt", s_done_n, 1);
    chk("a_err_cnt", s_err_n, 0);
    chk("a_popcount", int'(s_pc), pc_exp(47));

    // pixels without sof while idle are ignored
    drv(1, 1, 0, 0); drv(1, 1, 0, 1);
    gap(3);
    chk("idle_ignored", sa.size(), 0);

    // frame B: sof mid-line0 (with eol) -> error, 1-bit word at addr 0
    drv(1, 1, 1, 0);
    for (int k = 0; k < 9; k++) drv(1, 1, 0, 0);
    drv(1, 1, 1, 1);
    gap(3);
    chk("b_err1", s_err_n, 1);
    exp_s("b_sofeol", 0, 16'h0001, 0);
    chk("b_pc_hold", int'(s_pc), pc_exp(47));
    for (int k = 0; k < 22; k++) drv(1, (k % 2) == 0, 0, 0);
    drv(1, 1, 0, 1);
    drv(1, 0, 0, 1);
    gap(3);
    exp_s("b_l1w0", 2, 16'h5555, 0);
    exp_s("b_l1w1", 3, 16'h0005, 0);
    exp_s("b_l2w0", 4, 16'h0000, 0);
    drv(1, 1, 1, 0);
    gap(2);
    chk("b_err2", s_err_n, 2);
    chk("b_err_nowrite", sa.size(), 0);
    drv(1, 1, 0, 0); drv(1, 1, 0, 1);
    drv(1, 1, 0, 1); drv(1, 1, 0, 1); drv(1, 1, 0, 1);
    gap(3);
    exp_s("b_r_l0", 0, 16'h0007, 0);
    exp_s("b_r_l1", 2, 16'h0001, 0);
    exp_s("b_r_l2", 4, 16'h0001, 0);
    exp_s("b_r_l3", 6, 16'h0001, 1);
    chk("b_done_cnt", s_done_n, 2);
    chk("b_popcount", int'(s_pc), pc_exp(6));

    // async reset mid-frame: no partial write, restart needs sof
    drv(1, 1, 1, 0);
    for (int k = 0; k < 4; k++) drv(1, 1, 0, 0);
    @(posedge clk); #2;
    s_vld = 0; rst = 1;
    @(negedge clk);
    chk("mid_rst_we", int'(s_we), 0);
    chk("mid_rst_pc", int'(s_pc), 0);
    chk("mid_rst_nowrite", sa.size(), 0);
    @(posedge clk); #1 rst = 0;
    drv(1, 1, 0, 0); drv(1, 1, 0, 1);
    gap(3);
    chk("post_rst_ignored", sa.size(), 0);
    drv(1, 1, 1, 1);
    gap(3);
    exp_s("post_rst_sof", 0, 16'h0001, 0);
    chk("post_rst_err", s_err_n, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
